// File: rtl/muldiv_unit_if.sv
// Command/result bundle between the execute stage and the multiply/divide unit.
// master drives the operation request; slave is the unit returning busy/done and HI/LO.
interface muldiv_unit_if #(parameter int M = 32);
    logic         start;
    logic [1:0]   op;
    logic [M-1:0] srcA;
    logic [M-1:0] srcB;
    logic         mthi;
    logic         mtlo;
    logic         busy;
    logic         done;
    logic [M-1:0] hi;
    logic [M-1:0] lo;

    modport master (output start, op, srcA, srcB, mthi, mtlo,
                    input  busy, done, hi, lo);
    modport slave  (input  start, op, srcA, srcB, mthi, mtlo,
                    output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// MULT/MULTU/DIV/DIVU unit with HI/LO; shift-add multiply, restoring divide on magnitudes.
// Latency M cycles after accept (MULDIV_FAST_MUL_EN: multiply completes at the accept edge).
// No queuing: start/mthi/mtlo are ignored while busy; the pipeline stalls on busy.
module muldiv_unit #(parameter int M = 32) (
    input  logic          CLK,
    input  logic          CLR,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(M + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          signed_q;
    logic [M-1:0]  a_q, b_q, acc, quo, hi_q, lo_q;

    logic          idle_like, accept, fast_mul, last;
    logic          in_sa, in_sb, sgn_a, sgn_b;
    logic [M-1:0]  in_mag_a, in_mag_b, mag_a, mag_b;
    logic [M:0]    mul_sum, div_sh;
    logic          div_ge;
    logic [M-1:0]  div_diff, acc_nxt, quo_nxt, quot, rem;
    logic [2*M-1:0] prod_mag, prod;

    assign idle_like = (state == IDLE) || (state == DONE);
    assign accept    = idle_like && bus.start;
    assign last      = (cnt == CW'(1));

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*M-1:0] fast_a, fast_b, fast_prod;
    assign fast_mul  = ~bus.op[1];
    assign fast_a    = {{M{~bus.op[0] & bus.srcA[M-1]}}, bus.srcA};
    assign fast_b    = {{M{~bus.op[0] & bus.srcB[M-1]}}, bus.srcB};
    assign fast_prod = fast_a * fast_b;
`else
    assign fast_mul  = 1'b0;
`endif

    // Operand magnitudes at accept time seed the iteration register.
    assign in_sa    = ~bus.op[0] & bus.srcA[M-1];
    assign in_sb    = ~bus.op[0] & bus.srcB[M-1];
    assign in_mag_a = in_sa ? -bus.srcA : bus.srcA;
    assign in_mag_b = in_sb ? -bus.srcB : bus.srcB;

    assign sgn_a = signed_q & a_q[M-1];
    assign sgn_b = signed_q & b_q[M-1];
    assign mag_a = sgn_a ? -a_q : a_q;
    assign mag_b = sgn_b ? -b_q : b_q;

    assign mul_sum  = {1'b0, acc} + (quo[0] ? {1'b0, mag_a} : {(M+1){1'b0}});
    assign div_sh   = {acc, quo[M-1]};
    assign div_ge   = (div_sh >= {1'b0, mag_b});
    // When div_ge holds the difference is below mag_b, so M bits suffice.
    assign div_diff = div_sh[M-1:0] - mag_b;

    always_comb begin
        acc_nxt = div_ge ? div_diff : div_sh[M-1:0];
        quo_nxt = {quo[M-2:0], div_ge};
        if (state == MUL) begin
            acc_nxt = mul_sum[M:1];
            quo_nxt = {mul_sum[0], quo[M-1:1]};
        end
    end

    assign prod_mag = {acc_nxt, quo_nxt};
    assign prod     = (sgn_a ^ sgn_b) ? -prod_mag : prod_mag;
    assign quot     = (sgn_a ^ sgn_b) ? -quo_nxt : quo_nxt;
    assign rem      = sgn_a ? -acc_nxt : acc_nxt;

    always_ff @(posedge CLK) begin
        if (CLR) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (accept) state_nxt = bus.op[1] ? DIV : (fast_mul ? DONE : MUL);
            end
            MUL, DIV: if (last) state_nxt = DONE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            MUL, DIV: bus.busy = 1'b1;
            DONE:     bus.done = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            cnt      <= '0;
            signed_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            quo      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else if (idle_like) begin
            if (bus.mthi) hi_q <= bus.srcA;
            if (bus.mtlo) lo_q <= bus.srcA;
            if (accept) begin
                cnt      <= CW'(M);
                signed_q <= ~bus.op[0];
                a_q      <= bus.srcA;
                b_q      <= bus.srcB;
                acc      <= '0;
                quo      <= bus.op[1] ? in_mag_a : in_mag_b;
`ifdef MULDIV_FAST_MUL_EN
                if (fast_mul) {hi_q, lo_q} <= fast_prod;
`endif
            end
        end else begin
            cnt <= cnt - CW'(1);
            acc <= acc_nxt;
            quo <= quo_nxt;
            if (last) begin
                if (state == MUL) begin
                    {hi_q, lo_q} <= prod;
                end else if (b_q == '0) begin
                    hi_q <= a_q;
                    lo_q <= '1;
                end else begin
                    hi_q <= rem;
                    lo_q <= quot;
                end
            end
        end
    end

    assign bus.hi = hi_q;
    assign bus.lo = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit; expected results queued at issue, checked on done.
module tb_muldiv_unit;
    localparam int M = 32;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    logic CLK = 1'b0;
    logic CLR = 1'b1;
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;
    exp_t sb[$];

    muldiv_unit_if #(.M(M)) bus ();
    muldiv_unit #(.M(M)) u_dut (.CLK(CLK), .CLR(CLR), .bus(bus));

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, req);
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_hi"}, 64'(bus.hi), 64'(e.hi));
                chk({e.name, "_lo"}, 64'(bus.lo), 64'(e.lo));
                chk({e.name, "_done_cycle"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic issue(input string nm, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        int   lat;
        int   bc;
        lat = M;
`ifdef MULDIV_FAST_MUL_EN
        if (!o[1]) lat = 0;
`endif
        @(posedge CLK); #1;
        bus.start = 1'b1; bus.op = o; bus.srcA = a; bus.srcB = b;
        e.name = nm; e.hi = ehi; e.lo = elo; e.cyc = cyc + 1 + lat;
        sb.push_back(e);
        @(posedge CLK); #1;
        bus.start = 1'b0;
        bus.srcA = $urandom; bus.srcB = $urandom; bus.op = 2'($urandom_range(3, 0));
        bc = 0;
        for (int i = 0; i < M + 4; i++) begin
            @(negedge CLK);
            if (bus.busy === 1'b1) bc++;
        end
        chk({nm, "_busy_cycles"}, 64'(bc), 64'(lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.op = 2'b00; bus.srcA = '0; bus.srcB = '0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_hi", 64'(bus.hi), 64'h0);
        chk("reset_lo", 64'(bus.lo), 64'h0);
        chk("reset_busy", 64'(bus.busy), 64'h0);
        chk("reset_done", 64'(bus.done), 64'h0);
        CLR = 1'b0;

        issue("multu_max2",  2'b01, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE);
        issue("mult_m3x7",   2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB);
        issue("mult_m5xm6",  2'b00, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E);
        issue("mult_minsq",  2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        issue("multu_maxsq", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        issue("div_m7_2",    2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        issue("divu_100_7",  2'b11, 32'd100,      32'd7,        32'd2,        32'd14);
        issue("div_7_m2",    2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        issue("divu_by0",    2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF);
        issue("div_ovf",     2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        issue("div_m5_by0",  2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF);

        // Abort a divide with CLR: no result, no done pulse.
        @(posedge CLK); #1;
        bus.start = 1'b1; bus.op = 2'b11; bus.srcA = 32'd100; bus.srcB = 32'd7;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge CLK);
        #1 CLR = 1'b1;
        @(posedge CLK); #1;
        CLR = 1'b0;
        @(negedge CLK);
        chk("abort_hi", 64'(bus.hi), 64'h0);
        chk("abort_lo", 64'(bus.lo), 64'h0);
        chk("abort_busy", 64'(bus.busy), 64'h0);
        chk("abort_done", 64'(bus.done), 64'h0);
        repeat (M + 4) @(posedge CLK);

        // Fresh divide; a start/mthi/mtlo at cycle 15 must be ignored, then mtlo in DONE.
        begin
            exp_t e;
            @(posedge CLK); #1;
            bus.start = 1'b1; bus.op = 2'b11; bus.srcA = 32'd100; bus.srcB = 32'd7;
            e.name = "post_clr_divu"; e.hi = 32'd2; e.lo = 32'd14; e.cyc = cyc + 1 + M;
            sb.push_back(e);
            @(posedge CLK); #1;
            bus.start = 1'b0;
            repeat (14) @(posedge CLK);
            #1;
            bus.start = 1'b1; bus.op = 2'b01; bus.srcA = 32'h55; bus.srcB = 32'h3;
            bus.mthi = 1'b1; bus.mtlo = 1'b1;
            @(posedge CLK); #1;
            bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
            repeat (M - 16) @(posedge CLK);
            #1;
            chk("busy_before_done", 64'(bus.busy), 64'h1);
            @(posedge CLK); #1;
            bus.mtlo = 1'b1; bus.srcA = 32'hAB;
            @(posedge CLK); #1;
            bus.mtlo = 1'b0;
            @(negedge CLK);
            chk("mtlo_done_lo", 64'(bus.lo), 64'hAB);
            chk("mtlo_done_hi", 64'(bus.hi), 64'h2);
            chk("ignored_start_busy", 64'(bus.busy), 64'h0);
        end

        @(posedge CLK); #1;
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.srcA = 32'h77;
        @(posedge CLK); #1;
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        @(negedge CLK);
        chk("mthilo_hi", 64'(bus.hi), 64'h77);
        chk("mthilo_lo", 64'(bus.lo), 64'h77);

        repeat (4) @(posedge CLK);
        chk("pending_results", 64'(sb.size()), 64'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
